// File: rtl/button_int_ctrl_pkg.sv
// Shared constants for the button interrupt presenter and CPU interrupt logic.
// FSM encoding, button count and per-button interrupt vector addresses.
package button_int_ctrl_pkg;

    localparam int NBTN = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESENT = 2'd1,
        ST_GAP     = 2'd2
    } state_t;

    localparam logic [15:0] VEC_BTN3 = 16'h0F80;
    localparam logic [15:0] VEC_BTN2 = 16'h0FA0;
    localparam logic [15:0] VEC_BTN1 = 16'h0FC0;
    localparam logic [15:0] VEC_BTN0 = 16'h0FE0;

    function automatic logic [15:0] btn_vec(input logic [1:0] idx);
        logic [15:0] v;
        unique case (idx)
            2'd3:    v = VEC_BTN3;
            2'd2:    v = VEC_BTN2;
            2'd1:    v = VEC_BTN1;
            default: v = VEC_BTN0;
        endcase
        return v;
    endfunction

    // Bit 3 wins; result is one-hot or zero.
    function automatic logic [NBTN-1:0] hi_onehot(input logic [NBTN-1:0] v);
        logic [NBTN-1:0] r;
        r = '0;
        priority case (1'b1)
            v[3]:    r = 4'b1000;
            v[2]:    r = 4'b0100;
            v[1]:    r = 4'b0010;
            v[0]:    r = 4'b0001;
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/button_int_ctrl_if.sv
// Bundle between the button conditioner and the CPU-side top level.
// The block itself uses the slave view.
interface button_int_ctrl_if;
    import button_int_ctrl_pkg::*;

    logic [NBTN-1:0] btn_n;
    logic            int_ack;
    logic [NBTN-1:0] buttons_pressed;
    logic [NBTN-1:0] btn_level;
    logic [NBTN-1:0] pending;

    modport master (
        output btn_n,
        output int_ack,
        input  buttons_pressed,
        input  btn_level,
        input  pending
    );

    modport slave (
        input  btn_n,
        input  int_ack,
        output buttons_pressed,
        output btn_level,
        output pending
    );

endinterface

// File: rtl/btn_debounce.sv
// Two-flop synchroniser and restart-on-agreement debounce for one button.
// o_rise marks the edge on which the debounced level goes high.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_btn_n,
    output logic o_level,
    output logic o_rise
);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_level;
    logic [CNT_W-1:0] r_cnt;
    logic             w_s;
    logic             w_hit;

    assign w_s   = ~r_sync2;
    assign w_hit = (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= i_btn_n;
            r_sync2 <= r_sync1;
        end
    end

    // Any cycle of agreement restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_level <= 1'b0;
            r_cnt   <= '0;
        end else if (w_s == r_level) begin
            r_cnt   <= '0;
        end else if (w_hit) begin
            r_level <= w_s;
            r_cnt   <= '0;
        end else begin
            r_cnt   <= r_cnt + CNT_W'(1);
        end
    end

    assign o_level = r_level;
    assign o_rise  = w_s & ~r_level & w_hit;

endmodule

// File: rtl/button_int_ctrl.sv
// Debounces four active-low buttons and presents latched press requests
// to the CPU one at a time, highest index first, until acknowledged.
module button_int_ctrl
    import button_int_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    button_int_ctrl_if.slave   bus
);

    logic [NBTN-1:0] w_level;
    logic [NBTN-1:0] w_rise;
    logic [NBTN-1:0] r_pending;
    logic [NBTN-1:0] r_sel;
    logic [NBTN-1:0] w_sel_nxt;
    logic [NBTN-1:0] w_clr;
    state_t          r_state;
    state_t          w_state_nxt;

    for (genvar g = 0; g < NBTN; g++) begin : g_db
        btn_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_db (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_btn_n (bus.btn_n[g]),
            .o_level (w_level[g]),
            .o_rise  (w_rise[g])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE:    if (|r_pending)  w_state_nxt = ST_PRESENT;
            ST_PRESENT: if (bus.int_ack) w_state_nxt = ST_GAP;
            ST_GAP:     w_state_nxt = ST_IDLE;
            default:    w_state_nxt = ST_IDLE;
        endcase
    end

    // Selection only changes in IDLE, so a later press never pre-empts.
    always_comb begin
        w_sel_nxt = r_sel;
        w_clr     = '0;
        unique case (r_state)
            ST_IDLE: begin
                if (|r_pending) w_sel_nxt = hi_onehot(r_pending);
            end
            ST_PRESENT: begin
                if (bus.int_ack) begin
                    w_clr     = r_sel;
                    w_sel_nxt = '0;
                end
            end
            ST_GAP:  w_sel_nxt = '0;
            default: w_sel_nxt = '0;
        endcase
    end

    // A rise on the acknowledged bit wins over its clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sel     <= '0;
            r_pending <= '0;
        end else begin
            r_sel     <= w_sel_nxt;
            r_pending <= (r_pending & ~w_clr) | w_rise;
        end
    end

    assign bus.buttons_pressed = r_sel;
    assign bus.btn_level       = w_level;
    assign bus.pending         = r_pending;

endmodule

// File: tb/tb_button_int_ctrl.sv
// Directed scenarios plus random stimulus for button_int_ctrl,
// checked every cycle against a behavioural model of the press/present rules.
module tb_button_int_ctrl;

    localparam int D  = 4;
    localparam int CW = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    button_int_ctrl_if bif();

    button_int_ctrl #(
        .DEBOUNCE_CYCLES (D),
        .CNT_W           (CW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif)
    );

    int n_chk  = 0;
    int n_fail = 0;

    logic [3:0] m_p1, m_p2, m_lvl, m_pend, m_bp;
    logic [3:0] m_sh [D];
    bit         m_pres, m_gap;
    int         m_cur;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp,
                     $time);
        end
    endtask

    function automatic int hi_idx(input logic [3:0] v);
        for (int i = 3; i >= 0; i--) if (v[i]) return i;
        return -1;
    endfunction

    task automatic m_reset();
        m_p1 = 4'hF; m_p2 = 4'hF;
        m_lvl = '0; m_pend = '0; m_bp = '0;
        for (int k = 0; k < D; k++) m_sh[k] = '0;
        m_pres = 0; m_gap = 0; m_cur = 0;
    endtask

    // Level flips once the last D synchronised samples all disagree with it.
    task automatic m_step();
        logic [3:0] s, rise, old_p;
        bit same;
        s = ~m_p2;
        for (int k = D - 1; k > 0; k--) m_sh[k] = m_sh[k-1];
        m_sh[0] = s;
        rise = '0;
        for (int i = 0; i < 4; i++) begin
            same = 1;
            for (int k = 0; k < D; k++) if (m_sh[k][i] != s[i]) same = 0;
            if (same && s[i] != m_lvl[i]) begin
                m_lvl[i] = s[i];
                rise[i] = s[i];
            end
        end
        old_p = m_pend;
        if (m_pres && bif.int_ack) m_pend[m_cur] = 1'b0;
        m_pend = m_pend | rise;
        if (m_pres) begin
            if (bif.int_ack) begin m_pres = 0; m_gap = 1; end
        end else if (m_gap) begin
            m_gap = 0;
        end else if (old_p != 0) begin
            m_cur = hi_idx(old_p);
            m_pres = 1;
        end
        m_bp = m_pres ? 4'(1 << m_cur) : 4'h0;
        m_p2 = m_p1;
        m_p1 = bif.btn_n;
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst_n) m_reset();
        else        m_step();
        #1;
        chk("bp", bif.buttons_pressed, m_bp);
        chk("lvl", bif.btn_level, m_lvl);
        chk("pend", bif.pending, m_pend);
        chk("onehot", ($countones(bif.buttons_pressed) <= 1), 1);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic ack_pulse();
        bif.int_ack = 1'b1;
        tick();
        bif.int_ack = 1'b0;
    endtask

    task automatic wait_bp(input string tag, input logic [3:0] exp,
                           input int lim);
        int n;
        n = 0;
        while (bif.buttons_pressed !== exp && n < lim) begin
            tick();
            n++;
        end
        chk(tag, bif.buttons_pressed, exp);
    endtask

    task automatic drain();
        bif.btn_n = 4'hF;
        for (int i = 0; i < 40; i++) begin
            bif.int_ack = m_pres;
            tick();
        end
        bif.int_ack = 1'b0;
        ticks(2);
    endtask

    logic [3:0] glitch [8];
    int cnt;

    initial begin
        bif.btn_n = 4'hF;
        bif.int_ack = 1'b0;
        m_reset();
        ticks(2);
        chk("rst_bp", bif.buttons_pressed, 0);
        rst_n = 1'b1;
        ticks(2);

        // Clean press on button 1
        bif.btn_n = 4'b1101;
        ticks(5);
        chk("clean_lvl5", bif.btn_level[1], 0);
        tick();
        chk("clean_lvl6", bif.btn_level[1], 1);
        chk("clean_pend6", bif.pending[1], 1);
        chk("clean_bp6", bif.buttons_pressed, 0);
        tick();
        chk("clean_bp7", bif.buttons_pressed, 4'b0010);
        ticks(3);
        chk("clean_hold", bif.buttons_pressed, 4'b0010);
        ack_pulse();
        chk("clean_ackp", bif.pending[1], 0);
        chk("clean_gap", bif.buttons_pressed, 0);
        ticks(4);
        chk("clean_after", bif.buttons_pressed, 0);
        bif.btn_n = 4'hF;
        ticks(8);

        // Glitch rejection on button 2
        glitch = '{4'hB, 4'hB, 4'hB, 4'hF, 4'hB, 4'hB, 4'hB, 4'hF};
        for (int i = 0; i < 8; i++) begin
            bif.btn_n = glitch[i];
            tick();
            chk("glitch_lvl", bif.btn_level[2], 0);
        end
        ticks(8);
        chk("glitch_pend", bif.pending, 0);

        // Simultaneous presses on 0 and 3
        bif.btn_n = 4'b0110;
        wait_bp("prio_first", 4'b1000, 12);
        ack_pulse();
        chk("prio_gap", bif.buttons_pressed, 0);
        wait_bp("prio_second", 4'b0001, 4);
        ack_pulse();
        bif.btn_n = 4'hF;
        ticks(10);
        chk("prio_idle_p", bif.pending, 0);
        chk("prio_idle_b", bif.buttons_pressed, 0);

        // Set wins over clear on the presented bit
        bif.btn_n = 4'b1110;
        wait_bp("sw_first", 4'b0001, 12);
        bif.btn_n = 4'hF;
        ticks(8);
        bif.btn_n = 4'b1110;
        ticks(5);
        ack_pulse();
        chk("sw_pend", bif.pending[0], 1);
        chk("sw_gap", bif.buttons_pressed, 0);
        wait_bp("sw_again", 4'b0001, 4);
        drain();

        // Coalescing and no pre-empt
        bif.btn_n = 4'b1110;
        wait_bp("co_first", 4'b0001, 12);
        for (int r = 0; r < 2; r++) begin
            bif.btn_n = 4'hF;
            ticks(8);
            bif.btn_n = 4'b1110;
            ticks(8);
        end
        bif.btn_n = 4'b0110;
        ticks(8);
        chk("co_hold", bif.buttons_pressed, 4'b0001);
        ack_pulse();
        wait_bp("co_next", 4'b1000, 6);
        drain();

        // Async reset mid-present, button held through release
        bif.btn_n = 4'b1011;
        wait_bp("ar_first", 4'b0100, 12);
        #3;
        rst_n = 1'b0;
        #1;
        chk("ar_bp", bif.buttons_pressed, 0);
        chk("ar_lvl", bif.btn_level, 0);
        chk("ar_pend", bif.pending, 0);
        m_reset();
        tick();
        rst_n = 1'b1;
        cnt = 0;
        while (bif.buttons_pressed !== 4'b0100 && cnt < 20) begin
            tick();
            cnt++;
        end
        chk("ar_latency", cnt, D + 3);
        drain();

        // Random phase
        for (int i = 0; i < 2500; i++) begin
            for (int b = 0; b < 4; b++)
                if ($urandom_range(7) == 0) bif.btn_n[b] = ~bif.btn_n[b];
            bif.int_ack = m_pres ? ($urandom_range(3) == 0)
                                 : ($urandom_range(19) == 0);
            tick();
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
